// File: rtl/sr_iter.sv
// Iterative 32-bit right shifter (SRL/SRA) for the execute stage, one step per cycle.
// Define SR_FAST_EN to step by 4 while the remaining count allows it.
module sr_iter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_operand_a,
    input  logic [31:0] i_operand_b,
    input  logic        i_arith,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_sr_data
);

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic                fill_q, fill_d;
    logic [2:0]          step;

    // Upper shift-amount bits are architecturally ignored.
    logic unused_b;
    assign unused_b = ^i_operand_b[DATA_W-1:SHAMT_W];

    // Fill comes from the bit captured at start, never from the working register.
    function automatic logic [DATA_W-1:0] shift_fill(input logic [DATA_W-1:0] d,
                                                     input logic              f,
                                                     input logic [2:0]        s);
        logic [DATA_W-1:0] fill_mask;
        fill_mask = ~({DATA_W{1'b1}} >> s) & {DATA_W{f}};
        return (d >> s) | fill_mask;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        step    = 3'd1;
`ifdef SR_FAST_EN
        if (cnt_q >= SHAMT_W'(4)) begin
            step = 3'd4;
        end
`else
        step = 3'd1;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    data_d  = i_operand_a;
                    cnt_d   = i_operand_b[SHAMT_W-1:0];
                    fill_d  = i_arith & i_operand_a[DATA_W-1];
                    state_d = (i_operand_b[SHAMT_W-1:0] != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                data_d = shift_fill(data_q, fill_q, step);
                cnt_d  = cnt_q - {2'b00, step};
                if (cnt_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);
    assign o_sr_data = data_q;

endmodule

// File: tb/tb_sr_iter.sv
// Self-checking bench for sr_iter: directed vector table, multi-cycle corner
// sequences and randomized operations against a plain-arithmetic reference.
module tb_sr_iter;

`ifdef SR_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [31:0] i_operand_a;
    logic [31:0] i_operand_b;
    logic        i_arith;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_sr_data;

    int checks = 0;
    int errors = 0;

    sr_iter dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .i_arith     (i_arith),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_sr_data   (o_sr_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        arith;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: result from the shift operators, latency from the step rule.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic arith);
        int sh;
        sh = int'(b % 32);
        if (arith) return 32'($signed(a) >>> sh);
        return a >> sh;
    endfunction

    function automatic int ref_latency(input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        if (FAST) return sh / 4 + sh % 4 + 1;
        return sh + 1;
    endfunction

    // Launch one op from an IDLE cycle, scramble operands after capture, wait
    // for done, then sample one more edge so the block is IDLE on return.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic arith, input logic [31:0] exp, input int lat);
        int  cycles;
        bit  got;
        bit  busy_ok;
        @(negedge i_clk);
        i_operand_a = a;
        i_operand_b = b;
        i_arith     = arith;
        i_start     = 1'b1;
        cycles  = 0;
        got     = 1'b0;
        busy_ok = 1'b1;
        while (!got && cycles < 64) begin
            @(posedge i_clk);
            #1;
            cycles++;
            if (cycles == 1) begin
                i_start     = 1'b0;
                i_operand_a = $urandom;
                i_operand_b = $urandom;
                i_arith     = 1'($urandom);
            end
            if (!o_busy) busy_ok = 1'b0;
            got = o_done;
        end
        check({name, " done_seen"}, 32'(got), 32'd1);
        check({name, " latency"}, 32'(cycles), 32'(lat));
        check({name, " data"}, o_sr_data, exp);
        check({name, " busy_during"}, 32'(busy_ok), 32'd1);
        @(posedge i_clk);
        #1;
        check({name, " done_after"}, 32'(o_done), 32'd0);
        check({name, " busy_after"}, 32'(o_busy), 32'd0);
        check({name, " data_hold"}, o_sr_data, exp);
    endtask

    initial begin
        vec_t vecs[8];
        int   dones;
        logic [31:0] done_data;
        logic [31:0] ra, rb;
        logic        rarith;

        vecs[0] = '{32'h8000_0000, 32'd4,         1'b0, 32'h0800_0000, FAST ? 2  : 5};
        vecs[1] = '{32'h8000_0000, 32'd31,        1'b1, 32'hFFFF_FFFF, FAST ? 11 : 32};
        vecs[2] = '{32'h8000_0000, 32'd31,        1'b0, 32'h0000_0001, FAST ? 11 : 32};
        vecs[3] = '{32'h1234_5678, 32'hFFFF_FFE0, 1'b1, 32'h1234_5678, 1};
        vecs[4] = '{32'h7FFF_FFFF, 32'd31,        1'b1, 32'h0000_0000, FAST ? 11 : 32};
        vecs[5] = '{32'hF000_0000, 32'd5,         1'b1, 32'hFF80_0000, FAST ? 3  : 6};
        vecs[6] = '{32'hA5A5_A5A5, 32'd1,         1'b0, 32'h52D2_D2D2, 2};
        vecs[7] = '{32'h8000_0001, 32'd7,         1'b1, 32'hFF00_0000, FAST ? 5  : 8};

        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_operand_a = '0;
        i_operand_b = '0;
        i_arith     = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset done", 32'(o_done), 32'd0);
        check("reset data", o_sr_data, 32'h0);
        i_rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].arith,
                   vecs[i].exp, vecs[i].lat);
        end

        // Second start 3 cycles into a busy op must be dropped.
        @(negedge i_clk);
        i_operand_a = 32'hF000_000F;
        i_operand_b = 32'd8;
        i_arith     = 1'b0;
        i_start     = 1'b1;
        dones     = 0;
        done_data = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge i_clk);
            #1;
            i_start = (c == 3);
            if (c == 3) begin
                i_operand_a = 32'h0000_FFFF;
                i_operand_b = 32'd2;
                i_arith     = 1'b1;
            end
            if (o_done) begin
                dones++;
                done_data = o_sr_data;
            end
        end
        check("busy_start dones", 32'(dones), 32'd1);
        check("busy_start data", done_data, 32'h00F0_0000);
        check("busy_start idle", 32'(o_busy), 32'd0);

        // Reset in the middle of a long shift aborts without a done pulse.
        @(negedge i_clk);
        i_operand_a = 32'hDEAD_BEEF;
        i_operand_b = 32'd20;
        i_arith     = 1'b1;
        i_start     = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("midrst busy", 32'(o_busy), 32'd0);
        check("midrst done", 32'(o_done), 32'd0);
        check("midrst data", o_sr_data, 32'h0);
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge i_clk);
            #1;
            if (o_done) dones++;
        end
        check("midrst no_done", 32'(dones), 32'd0);
        run_op("after_rst", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h7FFF_FFFF, 2);

        // Reset wins over a simultaneous start.
        @(negedge i_clk);
        i_rst       = 1'b1;
        i_start     = 1'b1;
        i_operand_a = 32'h1111_1111;
        i_operand_b = 32'd3;
        @(posedge i_clk);
        #1;
        i_rst   = 1'b0;
        i_start = 1'b0;
        check("rst_vs_start busy", 32'(o_busy), 32'd0);
        check("rst_vs_start data", o_sr_data, 32'h0);

        // Back-to-back random ops: each starts the cycle after the previous done.
        for (int i = 0; i < 40; i++) begin
            ra     = $urandom;
            rb     = $urandom;
            rarith = 1'($urandom);
            if (i % 8 == 0) rb = {rb[31:5], 5'd31};
            if (i % 8 == 1) rb = {rb[31:5], 5'd0};
            if (i % 8 == 2) ra = {1'b1, ra[30:0]};
            run_op($sformatf("rand%0d", i), ra, rb, rarith,
                   ref_result(ra, rb, rarith), ref_latency(rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
